// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory responder and its word array.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } dmem_state_e;

    localparam logic [31:0] DMEM_BASE_ADDR  = 32'h1001_0000;
    localparam int          DMEM_BYTE_LANES = 4;

    // Word-index width; never narrower than one bit so a 1-word array still has an address.
    function automatic int dmem_idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Single-port word RAM with byte write enables and a registered read port.
// One access per enabled cycle; read data appears the cycle after and holds until the next read.
module dmem_word_array
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int AW         = 8
) (
    input  logic                       clk,
    input  logic                       i_en,
    input  logic                       i_we,
    input  logic [DMEM_BYTE_LANES-1:0] i_be,
    input  logic [AW-1:0]              i_addr,
    input  logic [DATA_WIDTH-1:0]      i_wdata,
    output logic [DATA_WIDTH-1:0]      o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < DMEM_BYTE_LANES; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: one request at a time, response valid WAIT_CYCLES+2 cycles after accept,
// held until rsp_ready_i; DMEM_ERR_CHECK_EN enables alignment/range error responses.
module data_memory_responder
    import mips_mem_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          MEMORY_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR    = DMEM_BASE_ADDR,
    parameter int          WAIT_CYCLES  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_write_i,
    input  logic [31:0]                req_addr_i,
    input  logic [DATA_WIDTH-1:0]      req_wdata_i,
    input  logic [DMEM_BYTE_LANES-1:0] req_be_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [DATA_WIDTH-1:0]      rsp_rdata_o,
    output logic                       rsp_error_o,
    output logic                       busy_o
);

    localparam int AW = dmem_idx_width(MEMORY_DEPTH);

    dmem_state_e                r_state;
    logic [3:0]                 r_cnt;
    logic                       r_req_rdy;
    logic                       r_rsp_vld;
    logic                       r_busy;
    logic                       r_write;
    logic                       r_err;
    logic [AW-1:0]              r_idx;
    logic [DATA_WIDTH-1:0]      r_wdata;
    logic [DMEM_BYTE_LANES-1:0] r_be;

    logic [31:0]                w_offset;
    logic [AW-1:0]              w_idx;
    logic                       w_err;
    logic                       w_arr_en;
    logic [DATA_WIDTH-1:0]      w_arr_rdata;

    assign w_offset = req_addr_i - BASE_ADDR;
    assign w_idx    = w_offset[AW+1:2];

`ifdef DMEM_ERR_CHECK_EN
    assign w_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i < BASE_ADDR) ||
                   ((w_offset >> 2) >= 32'(MEMORY_DEPTH));
`else
    // Out-of-range addresses simply wrap; the dropped offset bits are intentionally ignored.
    logic w_unused_off;
    assign w_unused_off = ^{w_offset[31:AW+2], w_offset[1:0]};
    assign w_err        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_req_rdy <= 1'b1;
            r_rsp_vld <= 1'b0;
            r_busy    <= 1'b0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_write   <= req_write_i;
                        r_err     <= w_err;
                        r_idx     <= w_idx;
                        r_wdata   <= req_wdata_i;
                        r_be      <= req_be_i;
                        r_cnt     <= 4'(WAIT_CYCLES);
                        r_req_rdy <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_rsp_vld <= 1'b1;
                    r_state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_vld <= 1'b0;
                        r_req_rdy <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The array is touched only in ACCESS, so its read register holds steady throughout RESP.
    assign w_arr_en = (r_state == ST_ACCESS) && !r_err;

    dmem_word_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEMORY_DEPTH),
        .AW         (AW)
    ) u_array (
        .clk     (clk),
        .i_en    (w_arr_en),
        .i_we    (r_write),
        .i_be    (r_be),
        .i_addr  (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_arr_rdata)
    );

    assign req_ready_o = r_req_rdy;
    assign rsp_valid_o = r_rsp_vld;
    assign busy_o      = r_busy;
    assign rsp_error_o = r_rsp_vld && r_err;
    assign rsp_rdata_o = (r_rsp_vld && !r_write && !r_err) ? w_arr_rdata : '0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_data_memory_responder;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_write [2];
    logic        rsp_ready [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic        rsp_error [2];
    logic        busy      [2];
    logic [31:0] rsp_rdata [2];

    logic [31:0] ref_mem [2][DEPTH];
    bit          known   [2][DEPTH];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    data_memory_responder dut0 (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_write_i(req_write[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_be_i(req_be[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]),
        .rsp_error_o(rsp_error[0]), .busy_o(busy[0])
    );

    data_memory_responder #(.WAIT_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_write_i(req_write[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_be_i(req_be[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]),
        .rsp_error_o(rsp_error[1]), .busy_o(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference address decode, written directly from the address rules.
    function automatic void ref_decode(input logic [31:0] a, output bit err, output int idx);
        logic [31:0] word;
        word = (a - BASE) / 4;
`ifdef DMEM_ERR_CHECK_EN
        err = (a % 4 != 0) || (a < BASE) || (word >= DEPTH);
        idx = err ? 0 : int'(word);
`else
        err = 1'b0;
        idx = int'(word % DEPTH);
`endif
    endfunction

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic check_idle_outputs(input int d, input string tag);
        check({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata[d], 32'd0);
        check({tag, "_rsp_error"}, 32'(rsp_error[d]), 32'd0);
        check({tag, "_busy"}, 32'(busy[d]), 32'd0);
    endtask

    // One complete transaction; hold>0 keeps rsp_ready low that many cycles while a
    // competing store to word 0 is offered, which must not be accepted.
    task automatic do_req(input int d, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int hold);
        bit          err;
        int          idx;
        int          lat;
        bit          chk_rd;
        logic [31:0] exp_rd;
        ref_decode(addr, err, idx);
        chk_rd = 1'b1;
        exp_rd = 32'd0;
        if (!wr && !err) begin
            if (known[d][idx]) exp_rd = ref_mem[d][idx];
            else chk_rd = 1'b0;
        end
        check("ready_before_req", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = addr;
        req_wdata[d] = wdata; req_be[d] = be;
        @(posedge clk); #1;
        req_valid[d] = 1'b0; req_write[d] = 1'($urandom); req_addr[d] = $urandom;
        req_wdata[d] = $urandom; req_be[d] = 4'($urandom);
        check("busy_after_accept", 32'(busy[d]), 32'd1);
        check("ready_after_accept", 32'(req_ready[d]), 32'd0);
        lat = 1;
        while (!rsp_valid[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rsp_latency", 32'(lat), 32'(wait_of(d) + 2));
        if (chk_rd) check("rsp_rdata", rsp_rdata[d], exp_rd);
        check("rsp_error", 32'(rsp_error[d]), 32'(err));
        if (wr && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ref_mem[d][idx][8*b +: 8] = wdata[8*b +: 8];
            end
            if (be == 4'hF) known[d][idx] = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            req_valid[d] = 1'b1; req_write[d] = 1'b1; req_addr[d] = BASE;
            req_be[d] = 4'hF; req_wdata[d] = $urandom;
            @(posedge clk); #1;
            check("hold_rsp_valid", 32'(rsp_valid[d]), 32'd1);
            if (chk_rd) check("hold_rsp_rdata", rsp_rdata[d], exp_rd);
            check("hold_rsp_error", 32'(rsp_error[d]), 32'(err));
            check("hold_req_ready", 32'(req_ready[d]), 32'd0);
            check("hold_busy", 32'(busy[d]), 32'd1);
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        check("after_hs_rsp_valid", 32'(rsp_valid[d]), 32'd0);
        check("after_hs_req_ready", 32'(req_ready[d]), 32'd1);
        check("after_hs_busy", 32'(busy[d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          last_acc;
        int          acc_q[$];
        bit          saw_rsp;
        int          k;
        int          sel;
        logic [31:0] a;

        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; rsp_ready[d] = 1'b0;
            req_addr[d] = '0; req_wdata[d] = '0; req_be[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs(0, "rst0");
        check_idle_outputs(1, "rst1");
        reset = 1'b0;
        @(posedge clk); #1;

        // Known contents for words 0..7 of the WAIT=2 instance.
        for (int i = 0; i < 8; i++) do_req(0, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 0);

        // Full store then load, then a single-lane merge.
        do_req(0, 1'b1, BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 0);
        do_req(0, 1'b0, BASE + 32'h4, 32'h0, 4'h0, 0);
        check("t1_model_word1", ref_mem[0][1], 32'hDEAD_BEEF);
        do_req(0, 1'b1, BASE + 32'h4, 32'h0000_00AA, 4'h1, 0);
        do_req(0, 1'b0, BASE + 32'h4, 32'h0, 4'h0, 0);

        // Response held 5 cycles while another request is offered.
        do_req(0, 1'b0, BASE + 32'h4, 32'h0, 4'h0, 5);
        do_req(0, 1'b0, BASE, 32'h0, 4'h0, 0);

        // Empty byte-enable store leaves the word unchanged.
        do_req(0, 1'b1, BASE + 32'h8, 32'hFFFF_FFFF, 4'h0, 0);
        do_req(0, 1'b0, BASE + 32'h8, 32'h0, 4'h0, 0);

        // Misaligned load and one-past-the-end store, then word 0 readback.
        do_req(0, 1'b0, BASE + 32'h2, 32'h0, 4'h0, 0);
        do_req(0, 1'b1, BASE + 32'(4 * DEPTH), 32'h1234_5678, 4'hF, 0);
        do_req(0, 1'b0, BASE, 32'h0, 4'h0, 0);

        // Reset while the store is waiting: no response, prior value survives.
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = BASE + 32'h8;
        req_wdata[0] = 32'h55; req_be[0] = 4'hF;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle_outputs(0, "midrst");
        saw_rsp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rsp_valid[0]) saw_rsp = 1'b1;
        end
        check("midrst_no_rsp", 32'(saw_rsp), 32'd0);
        do_req(0, 1'b0, BASE + 32'h8, 32'h0, 4'h0, 0);

        // Zero-wait instance: latency 2, back-to-back loads every 3 cycles.
        do_req(1, 1'b1, BASE + 32'hC, 32'hCAFE_F00D, 4'hF, 0);
        do_req(1, 1'b0, BASE + 32'hC, 32'h0, 4'h0, 0);
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = BASE + 32'hC;
        rsp_ready[1] = 1'b1;
        last_acc = -1;
        for (int c = 0; c < 16; c++) begin
            if (rsp_valid[1]) begin
                if (acc_q.size() == 0) check("b2b_rsp_without_accept", 32'd1, 32'd0);
                else check("b2b_rsp_cycle", 32'(c), 32'(acc_q.pop_front() + 2));
                check("b2b_rdata", rsp_rdata[1], ref_mem[1][3]);
            end
            if (req_ready[1]) begin
                if (last_acc >= 0) check("b2b_accept_spacing", 32'(c - last_acc), 32'd3);
                last_acc = c;
                acc_q.push_back(c);
            end
            @(posedge clk); #1;
        end
        req_valid[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rsp_ready[1] = 1'b0;
        check("b2b_drained_busy", 32'(busy[1]), 32'd0);

        // Random mix against the reference model.
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            k   = $urandom_range(0, 7);
            case (sel)
                0:       a = BASE + 32'(4 * k) + 32'($urandom_range(1, 3));
                1:       a = BASE + 32'(4 * DEPTH) + 32'(4 * k);
                2:       a = BASE - 32'd4;
                default: a = BASE + 32'(4 * k);
            endcase
            do_req(0, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
